apbs_swc: RTL

- APB completer (slave) for the switch fabric: the responder end of the APB bus driven by the APB master switch.
- Terminates one `pselx` line and exposes a bank of NREG 32-bit read/write registers to local hardware.
- Inserts a programmable number of wait states and flags bad accesses with `pslverr`.

---
 rtl/apb_swc_pkg.sv | 14 +
 rtl/apbs_swc_regbank.sv | 46 ++++
 rtl/apbs_swc.sv | 133 +++++++++++++
 3 files changed

// File: rtl/apb_swc_pkg.sv
// Shared definitions for the APB switch: bus widths and the state encoding
// used by both the master (IDLE/SETUP/ACCESS) and the completer (IDLE/ACCESS).
package apb_swc_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apbs_swc_regbank.sv
// Register bank for the APB completer: NREG 32-bit registers with a
// one-cycle write strobe that lines up with the updated register value.
module apbs_swc_regbank
    import apb_swc_pkg::*;
#(
    parameter int unsigned       NREG      = 8,
    parameter int unsigned       IDXW      = 3,
    parameter logic [APB_DW-1:0] RESET_VAL = 32'h0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   wr_en,
    input  logic [IDXW-1:0]        wr_idx,
    input  logic [APB_DW-1:0]      wr_data,
    output logic [NREG*APB_DW-1:0] reg_q,
    output logic [NREG-1:0]        reg_wstb
);

    logic [NREG*APB_DW-1:0] regs_q, regs_d;
    logic [NREG-1:0]        wstb_q, wstb_d;

    // Next register contents and strobe for a committing write.
    always_comb begin
        regs_d = regs_q;
        wstb_d = '0;
        if (wr_en) begin
            regs_d[{wr_idx, 5'b0} +: APB_DW] = wr_data;
            wstb_d[wr_idx]                   = 1'b1;
        end
    end

    // Register state; reset reloads every register with RESET_VAL.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            regs_q <= {NREG{RESET_VAL}};
            wstb_q <= '0;
        end else begin
            regs_q <= regs_d;
            wstb_q <= wstb_d;
        end
    end

    assign reg_q    = regs_q;
    assign reg_wstb = wstb_q;

endmodule

// File: rtl/apbs_swc.sv
// APB completer: decodes one pselx line onto a bank of NREG registers,
// inserts WAIT_CYCLES wait states and flags misaligned or out-of-range
// accesses with pslverr.
// Handshake: a transfer starts with a setup cycle (psel=1, penable=0) seen in
// IDLE; it completes on the single cycle where pready=1 while psel and
// penable are both high. Dropping psel before that aborts it silently.
module apbs_swc
    import apb_swc_pkg::*;
#(
    parameter logic [APB_AW-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned       NREG        = 8,
    parameter int unsigned       WAIT_CYCLES = 1,
    parameter logic [APB_DW-1:0] RESET_VAL   = 32'h0
) (
    input  logic                   pclk,
    input  logic                   prstn,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [APB_AW-1:0]      paddr,
    input  logic [APB_DW-1:0]      pwdata,
    output logic                   pready,
    output logic [APB_DW-1:0]      prdata,
    output logic                   pslverr,
    output logic [NREG*APB_DW-1:0] reg_q,
    output logic [NREG-1:0]        reg_wstb
);

    localparam int unsigned IDXW = (NREG > 1) ? $clog2(NREG) : 1;

    apb_state_e          state_q, state_d;
    logic [3:0]          count_q, count_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic                hit_q, hit_d;
    logic                pwrite_q, pwrite_d;
    logic [APB_DW-1:0]   pwdata_q, pwdata_d;
    logic [APB_DW-1:0]   prdata_r_q, prdata_r_d;

    logic [APB_AW-1:0]   dec_off;
    logic                dec_hit;
    logic [IDXW-1:0]     dec_idx;
    logic [APB_DW-1:0]   rd_word;
    logic                done;
    logic                wr_en;

    // Setup-phase address decode relative to BASE_ADDR (wraps at 32 bits).
    always_comb begin
        dec_off = paddr - BASE_ADDR;
        dec_hit = (dec_off[1:0] == 2'b00) && (dec_off < 32'(NREG * 4));
        dec_idx = dec_off[IDXW+1:2];
        rd_word = reg_q[{dec_idx, 5'b0} +: APB_DW];
    end

    // Next-state logic, latching of the transfer and the response outputs.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        hit_d      = hit_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        prdata_r_d = prdata_r_q;

        done = (state_q == ST_ACCESS) && (count_q == 4'd0) && psel && penable;

        case (state_q)
            ST_IDLE: begin
                if (psel && !penable) begin
                    state_d    = ST_ACCESS;
                    count_d    = 4'(WAIT_CYCLES);
                    idx_d      = dec_idx;
                    hit_d      = dec_hit;
                    pwrite_d   = pwrite;
                    pwdata_d   = pwdata;
                    prdata_r_d = (dec_hit && !pwrite) ? rd_word : '0;
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    state_d = ST_IDLE;
                end else if (penable) begin
                    if (count_q != 4'd0) begin
                        count_d = count_q - 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pready  = done;
        pslverr = done && !hit_q;
        prdata  = (done && !pwrite_q) ? prdata_r_q : '0;
        wr_en   = done && pwrite_q && hit_q;
    end

    // FSM, wait counter and latched transfer fields.
    always_ff @(posedge pclk) begin
        if (!prstn) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            hit_q      <= 1'b0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            prdata_r_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            hit_q      <= hit_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            prdata_r_q <= prdata_r_d;
        end
    end

    apbs_swc_regbank #(
        .NREG      (NREG),
        .IDXW      (IDXW),
        .RESET_VAL (RESET_VAL)
    ) u_regbank (
        .clk      (pclk),
        .rstn     (prstn),
        .wr_en    (wr_en),
        .wr_idx   (idx_q),
        .wr_data  (pwdata_q),
        .reg_q    (reg_q),
        .reg_wstb (reg_wstb)
    );

endmodule
